// File: rtl/aes_pkg.sv
// Shared AES types, constants and the GF(2^8) xtime helper.
package aes_pkg;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned WORD_W   = 32;
    localparam int unsigned STATE_W  = 128;
    localparam int unsigned NUM_ROWS = 4;
    localparam int unsigned NUM_COLS = 4;

    typedef logic [BYTE_W-1:0]  byte_t;
    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [STATE_W-1:0] state_t;

    // Low byte of the AES field polynomial 0x11B, folded in when bit 7 shifts out.
    localparam byte_t XTIME_RED = 8'h1B;

    // Multiply by x (i.e. by 02) in GF(2^8).
    function automatic byte_t xtime(input byte_t b);
        return {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? XTIME_RED : byte_t'(0));
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational forward/inverse MixColumns on a single 32-bit column.
module mix_column_word
    import aes_pkg::*;
(
    input  word_t col,
    input  logic  inv,
    output word_t mixed_c
);

    byte_t a   [NUM_ROWS];
    byte_t x2  [NUM_ROWS];
    byte_t x4  [NUM_ROWS];
    byte_t x8  [NUM_ROWS];
    byte_t m3  [NUM_ROWS];
    byte_t m9  [NUM_ROWS];
    byte_t mb  [NUM_ROWS];
    byte_t md  [NUM_ROWS];
    byte_t me  [NUM_ROWS];

    // Per-byte multiples built from xtime chains: 03, 09, 0b, 0d, 0e.
    always_comb begin
        for (int r = 0; r < NUM_ROWS; r++) begin
            a[r]  = col[WORD_W-1-BYTE_W*r -: BYTE_W];
            x2[r] = xtime(a[r]);
            x4[r] = xtime(x2[r]);
            x8[r] = xtime(x4[r]);
            m3[r] = x2[r] ^ a[r];
            m9[r] = x8[r] ^ a[r];
            mb[r] = x8[r] ^ x2[r] ^ a[r];
            md[r] = x8[r] ^ x4[r] ^ a[r];
            me[r] = x8[r] ^ x4[r] ^ x2[r];
        end
    end

    // Circulant row r weights byte r by the lead coefficient, then rotates.
    always_comb begin
        mixed_c = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (inv) begin
                mixed_c[WORD_W-1-BYTE_W*r -: BYTE_W] = me[r]
                                                     ^ mb[2'(r + 1)]
                                                     ^ md[2'(r + 2)]
                                                     ^ m9[2'(r + 3)];
            end else begin
                mixed_c[WORD_W-1-BYTE_W*r -: BYTE_W] = x2[r]
                                                     ^ m3[2'(r + 1)]
                                                     ^ a[2'(r + 2)]
                                                     ^ a[2'(r + 3)];
            end
        end
    end

endmodule

// File: rtl/mix_columns.sv
// AES MixColumns / InvMixColumns over a full 128-bit state, one registered stage.
module mix_columns
    import aes_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               inv,
    input  logic [STATE_W-1:0] in_state,
    output logic               out_valid,
    output logic [STATE_W-1:0] out_state
);

    state_t mixed_c;

    // Columns are independent, so each gets its own combinational mixer.
    for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
        mix_column_word u_mix_column_word (
            .col     (in_state[STATE_W-1-WORD_W*c -: WORD_W]),
            .inv     (inv),
            .mixed_c (mixed_c[STATE_W-1-WORD_W*c -: WORD_W])
        );
    end

    // Single output register; data only updates on a valid beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_state <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_state <= mixed_c;
            end
        end
    end

endmodule

// File: tb/tb_mix_columns.sv
// Self-checking bench for mix_columns with a queue-based scoreboard.
module tb_mix_columns;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         inv;
    logic [127:0] in_state;
    logic         out_valid;
    logic [127:0] out_state;

    int pass_cnt;
    int tot_cnt;
    logic [127:0] sb[$];
    logic [127:0] exp_v;
    logic [127:0] last_exp;

    mix_columns dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .inv       (inv),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_state (out_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Generic shift-and-add GF(2^8) multiply, polynomial 0x11B.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            if (aa[7]) aa = (aa << 1) ^ 8'h1b;
            else       aa = aa << 1;
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] st, input logic m);
        logic [7:0]   cf [4];
        logic [7:0]   col [4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (m) begin
            cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
        end else begin
            cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
        end
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) col[r] = st[127-32*c-8*r -: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ gmul(col[(r+k)%4], cf[k]);
                res[127-32*c-8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    task automatic drive(input logic [127:0] s, input logic m, input logic v);
        @(negedge clk);
        in_state = s;
        inv      = m;
        in_valid = v;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        inv      = 1'b0;
        in_state = '0;
        #1;
        tot_cnt++;
        if (out_valid !== 1'b0 || out_state !== 128'h0)
            $display("FAIL reset_state got v=%b s=%h want v=0 s=0", out_valid, out_state);
        else pass_cnt++;
        drive(128'h0123456789abcdef0123456789abcdef, 1'b0, 1'b1);
        @(posedge clk); #1;
        tot_cnt++;
        if (out_valid !== 1'b0 || out_state !== 128'h0)
            $display("FAIL reset_hold got v=%b s=%h want v=0 s=0", out_valid, out_state);
        else pass_cnt++;
        drive('0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        tot_cnt++;
        if (out_valid !== 1'b0 || out_state !== 128'h0)
            $display("FAIL reset_release_idle got v=%b s=%h want v=0 s=0", out_valid, out_state);
        else pass_cnt++;
    endtask

    task automatic test_known_vectors;
        logic [127:0] stim [2];
        logic         md   [2];
        stim[0] = 128'h6353e08c0960e104cd70b751bacad0e7; md[0] = 1'b0;
        stim[1] = 128'h5f72641557f5bc92f7be3b291db9f91a; md[1] = 1'b1;
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            drive(stim[i], md[i], 1'b1);
            sb.push_back(stim[1-i]);
            @(posedge clk); #1;
            tot_cnt++;
            if (out_valid !== 1'b1) $display("FAIL known_valid[%0d] got %b want 1", i, out_valid);
            else pass_cnt++;
            tot_cnt++;
            if (sb.size() == 0) $display("FAIL known_sb_empty[%0d] got empty want entry", i);
            else begin
                exp_v = sb.pop_front();
                if (out_state !== exp_v) $display("FAIL known_state[%0d] got %h want %h", i, out_state, exp_v);
                else pass_cnt++;
            end
        end
        drive('0, 1'b0, 1'b0);
    endtask

    task automatic test_column_vectors;
        logic [31:0]  vin  [6];
        logic [31:0]  vout [6];
        logic [127:0] s_in;
        logic [127:0] s_out;
        vin[0] = 32'hdb135345; vout[0] = 32'h8e4da1bc;
        vin[1] = 32'hf20a225c; vout[1] = 32'h9fdc589d;
        vin[2] = 32'h01010101; vout[2] = 32'h01010101;
        vin[3] = 32'hc6c6c6c6; vout[3] = 32'hc6c6c6c6;
        vin[4] = 32'hd4d4d4d5; vout[4] = 32'hd5d5d7d6;
        vin[5] = 32'h2d26314c; vout[5] = 32'h4d7ebdf8;
        sb.delete();
        for (int v = 0; v < 6; v++) begin
            for (int slot = 0; slot < 4; slot++) begin
                s_in  = 128'(vin[v])  << (32 * (3 - slot));
                s_out = 128'(vout[v]) << (32 * (3 - slot));
                for (int m = 0; m < 2; m++) begin
                    drive(m == 0 ? s_in : s_out, m[0], 1'b1);
                    sb.push_back(m == 0 ? s_out : s_in);
                    @(posedge clk); #1;
                    tot_cnt++;
                    if (sb.size() == 0)
                        $display("FAIL col_sb_empty v%0d s%0d m%0d", v, slot, m);
                    else begin
                        exp_v = sb.pop_front();
                        if (out_valid !== 1'b1 || out_state !== exp_v)
                            $display("FAIL col_vec v%0d s%0d m%0d got v=%b %h want v=1 %h",
                                     v, slot, m, out_valid, out_state, exp_v);
                        else pass_cnt++;
                    end
                end
            end
        end
        drive('0, 1'b0, 1'b0);
    endtask

    task automatic test_streaming;
        logic [127:0] st;
        sb.delete();
        for (int i = 0; i < 3; i++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            drive(st, i[0], 1'b1);
            sb.push_back(mix_ref(st, i[0]));
            if (i > 0) begin
                tot_cnt++;
                exp_v = sb.pop_front();
                if (out_valid !== 1'b1 || out_state !== exp_v)
                    $display("FAIL stream_beat%0d got v=%b %h want v=1 %h", i - 1, out_valid, out_state, exp_v);
                else pass_cnt++;
            end
            @(posedge clk); #1;
        end
        tot_cnt++;
        last_exp = sb.pop_front();
        if (out_valid !== 1'b1 || out_state !== last_exp)
            $display("FAIL stream_beat2 got v=%b %h want v=1 %h", out_valid, out_state, last_exp);
        else pass_cnt++;
        drive({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            tot_cnt++;
            if (out_valid !== 1'b0 || out_state !== last_exp)
                $display("FAIL stream_idle%0d got v=%b %h want v=0 %h", k, out_valid, out_state, last_exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_reset_midstream;
        logic [127:0] a;
        logic [127:0] b;
        logic [127:0] c;
        a = 128'h00112233445566778899aabbccddeeff;
        b = 128'hdeadbeefcafef00d0badc0de12345678;
        c = 128'h6353e08c0960e104cd70b751bacad0e7;
        sb.delete();
        drive(a, 1'b0, 1'b1);
        sb.push_back(mix_ref(a, 1'b0));
        @(posedge clk); #1;
        tot_cnt++;
        exp_v = sb.pop_front();
        if (out_valid !== 1'b1 || out_state !== exp_v)
            $display("FAIL rst_pre got v=%b %h want v=1 %h", out_valid, out_state, exp_v);
        else pass_cnt++;
        drive(b, 1'b1, 1'b1);
        sb.push_back(mix_ref(b, 1'b1));
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        tot_cnt++;
        if (out_valid !== 1'b0 || out_state !== 128'h0)
            $display("FAIL rst_async got v=%b %h want v=0 0", out_valid, out_state);
        else pass_cnt++;
        @(posedge clk); #1;
        tot_cnt++;
        if (out_valid !== 1'b0 || out_state !== 128'h0)
            $display("FAIL rst_during got v=%b %h want v=0 0", out_valid, out_state);
        else pass_cnt++;
        drive(c, 1'b0, 1'b1);
        rst_n = 1'b1;
        sb.push_back(128'h5f72641557f5bc92f7be3b291db9f91a);
        @(posedge clk); #1;
        tot_cnt++;
        if (sb.size() != 1) $display("FAIL rst_sb_depth got %0d want 1", sb.size());
        else begin
            exp_v = sb.pop_front();
            if (out_valid !== 1'b1 || out_state !== exp_v)
                $display("FAIL rst_first_beat got v=%b %h want v=1 %h", out_valid, out_state, exp_v);
            else pass_cnt++;
        end
        drive('0, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        logic [127:0] orig [1000];
        logic [127:0] fwd  [1000];
        int errs;
        for (int i = 0; i < 1000; i++) begin
            orig[i] = {$urandom, $urandom, $urandom, $urandom};
            fwd[i]  = mix_ref(orig[i], 1'b0);
        end
        for (int ph = 0; ph < 2; ph++) begin
            sb.delete();
            errs = 0;
            for (int i = 0; i <= 1000; i++) begin
                if (i < 1000) begin
                    drive(ph == 0 ? orig[i] : fwd[i], ph[0], 1'b1);
                    sb.push_back(ph == 0 ? fwd[i] : orig[i]);
                end else begin
                    drive('0, 1'b0, 1'b0);
                end
                if (i > 0) begin
                    tot_cnt++;
                    exp_v = sb.pop_front();
                    if (out_valid !== 1'b1 || out_state !== exp_v) begin
                        errs++;
                        if (errs <= 5)
                            $display("FAIL rand_ph%0d_beat%0d got v=%b %h want v=1 %h",
                                     ph, i - 1, out_valid, out_state, exp_v);
                    end else pass_cnt++;
                end
                @(posedge clk); #1;
            end
            tot_cnt++;
            if (out_valid !== 1'b0 || sb.size() != 0)
                $display("FAIL rand_ph%0d_drain got v=%b q=%0d want v=0 q=0", ph, out_valid, sb.size());
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt = 0;
        tot_cnt  = 0;
        test_reset();
        test_known_vectors();
        test_column_vectors();
        test_streaming();
        test_reset_midstream();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
